// File: rtl/panda_hazard_pkg.sv
// Shared types and constants for the panda hazard scoreboard slice.
package panda_hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned FWD_SEL_RF     = 0;

  typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

  // Select width needed to encode "register file" plus one code per source.
  function automatic int unsigned sel_width(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/panda_hazard_sb_if.sv
// Pipeline-side bus of the hazard scoreboard: operand, forward, issue and completion signals.
interface panda_hazard_sb_if #(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_FWD_SRC  = 2,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned SEL_W        = 2
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  logic                                flush_i;
  logic [NUM_RD_PORTS*REG_ADDR_W-1:0]  rs_addr_i;
  logic [NUM_RD_PORTS-1:0]             rs_used_i;
  logic [NUM_FWD_SRC*REG_ADDR_W-1:0]   fwd_rd_addr_i;
  logic [NUM_FWD_SRC-1:0]              fwd_rd_we_i;
  logic                                issue_valid_i;
  logic [REG_ADDR_W-1:0]               issue_rd_addr_i;
  logic                                issue_ready_o;
  logic                                cmpl_valid_i;
  logic [REG_ADDR_W-1:0]               cmpl_rd_addr_i;
  logic [NUM_RD_PORTS*SEL_W-1:0]       fwd_sel_o;
  logic                                stall_o;
  logic [NUM_REGS-1:0]                 busy_o;

  modport master (
    output flush_i, rs_addr_i, rs_used_i, fwd_rd_addr_i, fwd_rd_we_i,
           issue_valid_i, issue_rd_addr_i, cmpl_valid_i, cmpl_rd_addr_i,
    input  issue_ready_o, fwd_sel_o, stall_o, busy_o
  );

  modport slave (
    input  flush_i, rs_addr_i, rs_used_i, fwd_rd_addr_i, fwd_rd_we_i,
           issue_valid_i, issue_rd_addr_i, cmpl_valid_i, cmpl_rd_addr_i,
    output issue_ready_o, fwd_sel_o, stall_o, busy_o
  );

endinterface

// File: rtl/panda_fwd_prio_sel.sv
// Priority forward select for one read port: lowest-index (youngest) matching source wins.
module panda_fwd_prio_sel
  import panda_hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD_SRC = 2,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned SEL_W       = 2
) (
  input  logic [REG_ADDR_W-1:0]             rs_addr,
  input  logic [NUM_FWD_SRC*REG_ADDR_W-1:0] fwd_rd_addr,
  input  logic [NUM_FWD_SRC-1:0]            fwd_rd_we,
  output logic [SEL_W-1:0]                  sel_c
);

  // Scan oldest to youngest so the youngest match overwrites; x0 never forwards.
  always_comb begin
    sel_c = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD_SRC - 1; k >= 0; k--) begin
      if (fwd_rd_we[k] &&
          (fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          (fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
        sel_c = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/panda_hazard_sb.sv
// Forwarding select plus busy-bit scoreboard for variable-latency producers.
// Optional PANDA_HAZARD_PERF_EN adds a saturating stall-cycle counter.
module panda_hazard_sb
  import panda_hazard_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_FWD_SRC  = 2,
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  panda_hazard_sb_if.slave   bus
`ifdef PANDA_HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt_o
`endif
);

  localparam int unsigned SEL_W    = sel_width(NUM_FWD_SRC);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0]           busy_q;
  logic [NUM_REGS-1:0]           busy_d;
  logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel_c;
  logic                          cmpl_hit_issue_c;
  logic                          issue_ready_c;
  logic                          issue_acc_c;
  logic                          raw_stall_c;
  logic                          stall_c;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    panda_fwd_prio_sel #(
      .NUM_FWD_SRC (NUM_FWD_SRC),
      .REG_ADDR_W  (REG_ADDR_W),
      .SEL_W       (SEL_W)
    ) u_sel (
      .rs_addr     (bus.rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .fwd_rd_addr (bus.fwd_rd_addr_i),
      .fwd_rd_we   (bus.fwd_rd_we_i),
      .sel_c       (fwd_sel_c[p*SEL_W +: SEL_W])
    );
  end

  // A completion to the same register frees the slot this cycle, so WAW issue may proceed.
  always_comb begin
    cmpl_hit_issue_c = bus.cmpl_valid_i && (bus.cmpl_rd_addr_i == bus.issue_rd_addr_i);
    issue_ready_c    = !busy_q[bus.issue_rd_addr_i] || cmpl_hit_issue_c;
    issue_acc_c      = bus.issue_valid_i && issue_ready_c;
  end

  // RAW hazard unless the producer completes now (bypassed through the oldest source).
  always_comb begin
    raw_stall_c = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (bus.rs_used_i[p] &&
          busy_q[bus.rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]] &&
          !(bus.cmpl_valid_i &&
            (bus.cmpl_rd_addr_i == bus.rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]))) begin
        raw_stall_c = 1'b1;
      end
    end
    stall_c = raw_stall_c || (bus.issue_valid_i && !issue_ready_c);
  end

  // Priority: flush > issue set > completion clear; register 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.cmpl_valid_i) begin
      busy_d[bus.cmpl_rd_addr_i] = 1'b0;
    end
    if (issue_acc_c && (bus.issue_rd_addr_i != '0)) begin
      busy_d[bus.issue_rd_addr_i] = 1'b1;
    end
    if (bus.flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.fwd_sel_o     = fwd_sel_c;
  assign bus.issue_ready_o = issue_ready_c;
  assign bus.stall_o       = stall_c;
  assign bus.busy_o        = busy_q;

`ifdef PANDA_HAZARD_PERF_EN
  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= '0;
    end else if (stall_c && (perf_stall_cnt_o != '1)) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
